// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// imem_loader_if : byte-stream handshake between an image source and the loader
// Revision 1.0
// ============================================================================
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : loads a checksummed byte-stream image into instruction memory
// Revision 1.0
// ============================================================================
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  wire logic              clk,
  input  wire logic              rst,
  imem_loader_if.slave           s_in,
  input  wire logic              i_load_start,
  output logic                   o_load_busy,
  output logic                   o_load_done,
  output logic                   o_load_err,
  output logic                   o_cpu_run,
  output logic [ADDR_W:0]        o_words_loaded,
  input  wire logic [ADDR_W-1:0] i_fetch_addr,
  output logic [31:0]            o_fetch_instr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [ADDR_W:0] r_words;
  logic [ADDR_W:0] r_n;
  logic [1:0]      r_bcnt;
  logic [7:0]      r_xor;
  logic [23:0]     r_word;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_hdr_ok;
  logic            w_last;
  logic [31:0]     w_word;

  assign w_accept = s_in.in_valid && r_ready;
  assign w_hdr_ok = (s_in.in_data != 8'd0) && (int'(s_in.in_data) <= DEPTH);
  assign w_last   = (r_words + (ADDR_W+1)'(1)) == r_n;
  // Word is assembled MSB first: three buffered bytes plus the one arriving now.
  assign w_word   = {r_word, s_in.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
      r_n     <= '0;
      r_bcnt  <= '0;
      r_xor   <= '0;
      r_word  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_load_start) begin
            r_state <= S_HDR;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_bcnt  <= '0;
            r_xor   <= '0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (w_hdr_ok) begin
              r_n     <= (ADDR_W+1)'(s_in.in_data);
              r_state <= S_DATA;
            end else begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_xor  <= r_xor ^ s_in.in_data;
            r_word <= w_word[23:0];
            if (r_bcnt == 2'd3) begin
              r_bcnt                   <= '0;
              r_mem[r_words[ADDR_W-1:0]] <= w_word;
              r_words                  <= r_words + (ADDR_W+1)'(1);
              if (w_last) begin
                r_state <= S_CHK;
              end
            end else begin
              r_bcnt <= r_bcnt + 2'd1;
            end
          end
        end
        S_CHK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            if (s_in.in_data == r_xor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_in.in_ready  = r_ready;
  assign o_load_busy    = r_busy;
  assign o_load_done    = r_done;
  assign o_load_err     = r_err;
  assign o_cpu_run      = r_done;
  assign o_words_loaded = r_words;

  always_comb begin
    o_fetch_instr = '0;
    if (int'(i_fetch_addr) < DEPTH) begin
      o_fetch_instr = r_mem[i_fetch_addr];
    end
  end

endmodule
`default_nettype wire
